// File: rtl/timekeeper_core_if.sv
// Time-set load channel between the set-time UI (master) and timekeeper_core (slave).
// Carries the BCD digit request and the accept/reject response pulses.
interface timekeeper_core_if;
  logic       load_en;
  logic [1:0] i_hours_left;
  logic [3:0] i_hours_right;
  logic [2:0] i_minutes_left;
  logic [3:0] i_minutes_right;
  logic [2:0] i_seconds_left;
  logic [3:0] i_seconds_right;
  logic       load_ack;
  logic       load_err;

  modport master (
    output load_en,
    output i_hours_left,
    output i_hours_right,
    output i_minutes_left,
    output i_minutes_right,
    output i_seconds_left,
    output i_seconds_right,
    input  load_ack,
    input  load_err
  );

  modport slave (
    input  load_en,
    input  i_hours_left,
    input  i_hours_right,
    input  i_minutes_left,
    input  i_minutes_right,
    input  i_seconds_left,
    input  i_seconds_right,
    output load_ack,
    output load_err
  );
endinterface

// File: rtl/timekeeper_core.sv
// Time-of-day counter (hh:mm:ss) with prescaler, validated BCD time-set load,
// 12h/24h BCD display, AM/PM flag and registered rollover pulses.
module timekeeper_core #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned PRESC_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_en,
    input  logic                  mode_12h,
    timekeeper_core_if.slave      ld,
    output logic [4:0]            o_hours,
    output logic [5:0]            o_minutes,
    output logic [5:0]            o_seconds,
    output logic [7:0]            o_hr_bcd,
    output logic [7:0]            o_min_bcd,
    output logic [7:0]            o_sec_bcd,
    output logic                  o_pm,
    output logic                  o_min_pulse,
    output logic                  o_hour_pulse,
    output logic                  o_day_pulse
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [4:0]         hours_q, hours_d;
    logic [5:0]         minutes_q, minutes_d;
    logic [5:0]         seconds_q, seconds_d;
    logic               min_pulse_q, min_pulse_d;
    logic               hour_pulse_q, hour_pulse_d;
    logic               day_pulse_q, day_pulse_d;
    logic               load_ack_q, load_ack_d;
    logic               load_err_q, load_err_d;

    logic               sec_tick;
    logic [5:0]         ld_hours;
    logic [6:0]         ld_minutes;
    logic [6:0]         ld_seconds;
    logic               load_ok;
    logic [4:0]         hr_disp;

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = '0;
        rem  = v;
        for (int unsigned i = 0; i < 5; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign sec_tick = run_en && (presc_q == PRESC_MAX);

    // Products are formed wide enough that out-of-range digits cannot alias
    // into a legal value before the range check.
    always_comb begin
        ld_hours   = 6'({4'b0, ld.i_hours_left}) * 6'd10 + 6'({2'b0, ld.i_hours_right});
        ld_minutes = 7'({4'b0, ld.i_minutes_left}) * 7'd10 + 7'({3'b0, ld.i_minutes_right});
        ld_seconds = 7'({4'b0, ld.i_seconds_left}) * 7'd10 + 7'({3'b0, ld.i_seconds_right});
        load_ok    = (ld.i_hours_right   <= 4'd9) && (ld_hours <= 6'd23) &&
                     (ld.i_minutes_left  <= 3'd5) && (ld.i_minutes_right <= 4'd9) &&
                     (ld.i_seconds_left  <= 3'd5) && (ld.i_seconds_right <= 4'd9);
    end

    always_comb begin
        presc_d      = presc_q;
        hours_d      = hours_q;
        minutes_d    = minutes_q;
        seconds_d    = seconds_q;
        min_pulse_d  = 1'b0;
        hour_pulse_d = 1'b0;
        day_pulse_d  = 1'b0;
        load_ack_d   = 1'b0;
        load_err_d   = 1'b0;

        // A load request, accepted or not, swallows any tick in the same cycle.
        if (ld.load_en) begin
            if (load_ok) begin
                hours_d    = ld_hours[4:0];
                minutes_d  = ld_minutes[5:0];
                seconds_d  = ld_seconds[5:0];
                presc_d    = '0;
                load_ack_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (run_en) begin
            presc_d = sec_tick ? '0 : presc_q + PRESC_W'(1);
            if (sec_tick) begin
                if (seconds_q == 6'd59) begin
                    seconds_d   = '0;
                    min_pulse_d = 1'b1;
                    if (minutes_q == 6'd59) begin
                        minutes_d    = '0;
                        hour_pulse_d = 1'b1;
                        if (hours_q == 5'd23) begin
                            hours_d     = '0;
                            day_pulse_d = 1'b1;
                        end else begin
                            hours_d = hours_q + 5'd1;
                        end
                    end else begin
                        minutes_d = minutes_q + 6'd1;
                    end
                end else begin
                    seconds_d = seconds_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            hours_q      <= '0;
            minutes_q    <= '0;
            seconds_q    <= '0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_pulse_q  <= 1'b0;
            load_ack_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            min_pulse_q  <= min_pulse_d;
            hour_pulse_q <= hour_pulse_d;
            day_pulse_q  <= day_pulse_d;
            load_ack_q   <= load_ack_d;
            load_err_q   <= load_err_d;
        end
    end

    always_comb begin
        hr_disp = hours_q;
        if (mode_12h) begin
            if (hours_q == 5'd0) begin
                hr_disp = 5'd12;
            end else if (hours_q > 5'd12) begin
                hr_disp = hours_q - 5'd12;
            end
        end
    end

    assign o_hours      = hours_q;
    assign o_minutes    = minutes_q;
    assign o_seconds    = seconds_q;
    assign o_hr_bcd     = to_bcd({1'b0, hr_disp});
    assign o_min_bcd    = to_bcd(minutes_q);
    assign o_sec_bcd    = to_bcd(seconds_q);
    assign o_pm         = (hours_q >= 5'd12);
    assign o_min_pulse  = min_pulse_q;
    assign o_hour_pulse = hour_pulse_q;
    assign o_day_pulse  = day_pulse_q;
    assign ld.load_ack  = load_ack_q;
    assign ld.load_err  = load_err_q;

endmodule
